// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared types and default widths for the wishbone request queue slice.
//   wb_req_t     : one queued core request {addr, data, we} at default widths
//   wb_q_state_t : issue FSM states of wb_req_queue
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package wb_pkg;

   localparam int unsigned WB_AW    = 32;
   localparam int unsigned WB_DW    = 32;
   localparam int unsigned WB_DEPTH = 4;

   typedef struct packed {
      logic [WB_AW-1:0]   addr;
      logic [WB_DW-1:0]   data;
      logic [WB_DW/8-1:0] we;
   } wb_req_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RESP
   } wb_q_state_t;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered occupancy. full/empty/level come only
// from the level register, so there is no combinational path from push to
// empty or from pop to full.
//   clk, rst          : clock, asynchronous active-high reset
//   push, push_data   : write request (ignored when full)
//   pop, pop_data     : read request (ignored when empty); pop_data shows head
//   full, empty, level: occupancy status
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module sync_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8,
   localparam int unsigned LW = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [LW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   // No bypass: a full FIFO refuses a push even when popped in the same cycle.
   assign full    = (count == LW'(DEPTH));
   assign empty   = (count == '0);
   assign level   = count;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: contents are only visible through level/empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/wb_req_queue.sv
// ---------------------------------------------------------------------------
// wb_req_queue
// Request buffer in front of a wishbone_master. Core requests are queued in a
// FIFO, issued one at a time to the master, and each completion is returned
// as a response with valid/ready backpressure, strictly in request order.
//   clk_i, rst_i                 : clock, asynchronous active-high reset
//   req_valid_i/req_ready_o      : core request handshake
//   req_addr_i/data_i/we_i       : request payload (we all-zero = read)
//   rsp_valid_o/rsp_ready_i      : response handshake
//   rsp_data_o, rsp_write_o      : read data, write flag
//   m_valid_o, m_addr_o, m_data_o, m_we_o : request to the master
//   m_valid_i, m_data_i          : one-cycle completion pulse from the master
//   level_o                      : FIFO occupancy
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module wb_req_queue
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = WB_DEPTH,
   parameter int unsigned AW    = WB_AW,
   parameter int unsigned DW    = WB_DW
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic [AW-1:0]            req_addr_i,
   input  logic [DW-1:0]            req_data_i,
   input  logic [DW/8-1:0]          req_we_i,
   output logic                     rsp_valid_o,
   input  logic                     rsp_ready_i,
   output logic [DW-1:0]            rsp_data_o,
   output logic                     rsp_write_o,
   output logic                     m_valid_o,
   output logic [AW-1:0]            m_addr_o,
   output logic [DW-1:0]            m_data_o,
   output logic [DW/8-1:0]          m_we_o,
   input  logic [DW-1:0]            m_data_i,
   input  logic                     m_valid_i,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int unsigned RW = AW + DW + DW/8;

   typedef struct packed {
      logic [AW-1:0]   addr;
      logic [DW-1:0]   data;
      logic [DW/8-1:0] we;
   } req_t;

   wb_q_state_t   state;
   req_t          head;
   logic [RW-1:0] head_bits;
   logic          full;
   logic          empty;
   logic          pop;

   assign head        = head_bits;
   assign req_ready_o = !full;
   assign pop         = (state == IDLE) && !empty;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (RW)
   ) u_fifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .push      (req_valid_i),
      .push_data ({req_addr_i, req_data_i, req_we_i}),
      .pop       (pop),
      .pop_data  (head_bits),
      .full      (full),
      .empty     (empty),
      .level     (level_o)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         m_valid_o   <= 1'b0;
         m_addr_o    <= '0;
         m_data_o    <= '0;
         m_we_o      <= '0;
         rsp_valid_o <= 1'b0;
         rsp_data_o  <= '0;
         rsp_write_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  m_addr_o <= head.addr;
                  m_data_o <= head.data;
                  m_we_o   <= head.we;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               // m_valid_o rises on the first ISSUE cycle, one edge after the
               // pop, so a push at edge N shows m_valid_o after edge N+2 and
               // a transaction takes master latency + 3 cycles. Completion
               // pulses are only honoured once the master has seen valid.
               if (!m_valid_o) begin
                  m_valid_o <= 1'b1;
               end else if (m_valid_i) begin
                  rsp_data_o  <= m_data_i;
                  rsp_write_o <= |m_we_o;
                  m_valid_o   <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  state       <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
